// File: rtl/c64_mem_defs.sv
// Shared definitions for the C64 memory-side stage: read-select codes,
// region bases and 6510 on-chip port addresses.
package c64_mem_defs;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned ROM_AW = 13;
  localparam int unsigned PAGE_AW = 12;

  typedef enum logic [SEL_W-1:0] {
    SEL_OPEN   = 3'd0,
    SEL_RAM    = 3'd1,
    SEL_BASIC  = 3'd2,
    SEL_KERNAL = 3'd3,
    SEL_CHAR   = 3'd4,
    SEL_IO     = 3'd5,
    SEL_PORT   = 3'd6
  } sel_e;

  localparam logic [ADDR_W-1:0] BASIC_BASE  = 16'hA000;
  localparam logic [ADDR_W-1:0] IO_BASE     = 16'hD000;
  localparam logic [ADDR_W-1:0] KERNAL_BASE = 16'hE000;
  localparam logic [ADDR_W-1:0] PORT_DDR_ADDR  = 16'h0000;
  localparam logic [ADDR_W-1:0] PORT_DATA_ADDR = 16'h0001;

endpackage

// File: rtl/c64_bank_decode.sv
// Combinational C64 bank decode: address plus LORAM/HIRAM/CHAREN to a read-select region.
module c64_bank_decode
  import c64_mem_defs::*;
(
  input  logic [ADDR_W-1:0] cpu_ab,
  input  logic              loram,
  input  logic              hiram,
  input  logic              charen,
  output sel_e              region
);

  logic [ADDR_W-1:0] basic_base;
  logic [ADDR_W-1:0] io_base;
  logic [ADDR_W-1:0] kernal_base;

  assign basic_base  = BASIC_BASE;
  assign io_base     = IO_BASE;
  assign kernal_base = KERNAL_BASE;

  always_comb begin
    region = SEL_RAM;
    if (cpu_ab[ADDR_W-1:1] == PORT_DDR_ADDR[ADDR_W-1:1]) begin
      region = SEL_PORT;
    end else if (cpu_ab[15:13] == basic_base[15:13]) begin
      region = (loram && hiram) ? SEL_BASIC : SEL_RAM;
    end else if (cpu_ab[15:12] == io_base[15:12]) begin
      // Both banking lines low maps the whole $D000 page to RAM regardless of CHAREN.
      if (!loram && !hiram) region = SEL_RAM;
      else if (charen)      region = SEL_IO;
      else                  region = SEL_CHAR;
    end else if (cpu_ab[15:13] == kernal_base[15:13]) begin
      region = hiram ? SEL_KERNAL : SEL_RAM;
    end
  end

endmodule

// File: rtl/c64_mem_bus.sv
// Memory-side stage behind the 6502 core: 6510 I/O port, bank decode, write
// strobes and the single-cycle registered read-data path.
module c64_mem_bus
  import c64_mem_defs::*;
#(
  parameter logic [7:0] DDR_RST  = 8'h00,
  parameter logic [7:0] PORT_RST = 8'h00,
  parameter logic [7:0] OPEN_BUS = 8'hFF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   cpu_ab,
  input  logic [DATA_W-1:0]   cpu_do,
  input  logic                cpu_we,
  output logic [DATA_W-1:0]   cpu_di,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic                ram_we,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [ROM_AW-1:0]   basic_addr,
  input  logic [DATA_W-1:0]   basic_rdata,
  output logic [ROM_AW-1:0]   kernal_addr,
  input  logic [DATA_W-1:0]   kernal_rdata,
  output logic [PAGE_AW-1:0]  char_addr,
  input  logic [DATA_W-1:0]   char_rdata,
  output logic [PAGE_AW-1:0]  io_addr,
  output logic                io_rd,
  output logic                io_we,
  output logic [DATA_W-1:0]   io_wdata,
  input  logic [DATA_W-1:0]   io_rdata,
  input  logic [DATA_W-1:0]   port_in,
  output logic [DATA_W-1:0]   port_out,
  output logic [DATA_W-1:0]   port_dir
);

  logic [DATA_W-1:0] eff;
  sel_e              region;
  sel_e              sel_q;
  logic [DATA_W-1:0] port_q;
  logic              is_io;

  // Output pins drive the register value, input pins read the external level.
  assign eff = (port_dir & port_out) | (~port_dir & port_in);

  c64_bank_decode u_decode (
    .cpu_ab (cpu_ab),
    .loram  (eff[0]),
    .hiram  (eff[1]),
    .charen (eff[2]),
    .region (region)
  );

  assign ram_addr    = cpu_ab;
  assign ram_wdata   = cpu_do;
  assign basic_addr  = cpu_ab[ROM_AW-1:0];
  assign kernal_addr = cpu_ab[ROM_AW-1:0];
  assign char_addr   = cpu_ab[PAGE_AW-1:0];
  assign io_addr     = cpu_ab[PAGE_AW-1:0];
  assign io_wdata    = cpu_do;

  // Strobes are gated by reset so nothing is issued during or across a reset.
  assign is_io  = (region == SEL_IO);
  assign ram_we = !reset && cpu_we && !is_io;
  assign io_we  = !reset && cpu_we && is_io;
  assign io_rd  = !reset && !cpu_we && is_io;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port_dir <= DDR_RST;
      port_out <= PORT_RST;
    end else if (cpu_we) begin
      if (cpu_ab == PORT_DDR_ADDR)  port_dir <= cpu_do;
      if (cpu_ab == PORT_DATA_ADDR) port_out <= cpu_do;
    end
  end

  // Read pipeline: remember which source answers the access presented this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q  <= SEL_OPEN;
      port_q <= '0;
    end else begin
      sel_q <= region;
      if (region == SEL_PORT) port_q <= (cpu_ab == PORT_DDR_ADDR) ? port_dir : eff;
    end
  end

  always_comb begin
    cpu_di = OPEN_BUS;
    case (sel_q)
      SEL_RAM:    cpu_di = ram_rdata;
      SEL_BASIC:  cpu_di = basic_rdata;
      SEL_KERNAL: cpu_di = kernal_rdata;
      SEL_CHAR:   cpu_di = char_rdata;
      SEL_IO:     cpu_di = io_rdata;
      SEL_PORT:   cpu_di = port_q;
      default:    cpu_di = OPEN_BUS;
    endcase
  end

endmodule
